calc_inverse_unit: RTL
======================

CALC_INVERSE_UNIT -- requirements
Module: calc_inverse_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port in_valid, input, 1 bit: the request fields are valid.
REQ-004 SHALL have port in_ready, output, 1 bit: the unit can accept a request.
REQ-005 SHALL have port is_inv_bmi, input, 1 bit: select inverse BMI (target weight from BMI x100 and height).
REQ-006 SHALL have port is_inv_bmr, input, 1 bit: select inverse BMR (target weight from BMR in kcal, height, age and gender).
REQ-007 SHALL have port height, input, 32 bits: height in cm, unsigned.
REQ-008 SHALL have port target, input, 32 bits: BMI x100 or BMR in kcal, unsigned.
REQ-009 SHALL have port funct7, input, 7 bits: [6] is gender (1=male, 0=female), [5:0] is age in years.
REQ-010 SHALL have port out_valid, output, 1 bit: result and err are valid.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 SHALL have port result, output, 32 bits: weight in kg, unsigned, truncated.
REQ-013 SHALL have port err, output, 1 bit: illegal opcode or negative intermediate.

Function
REQ-014 SHALL implement FSM states IDLE, PREP, DIV and DONE; in_ready = (state==IDLE).
REQ-015 SHALL accept a request on an edge where in_valid && in_ready, capture all request fields and go to PREP; later input changes are ignored.
REQ-016 In PREP, if exactly one of is_inv_bmi/is_inv_bmr was captured high, SHALL load the dividend and divisor and go to DIV; otherwise it SHALL set err=1, result=0 and go to DONE.
REQ-017 For inverse BMI, SHALL compute h2 = (height*height mod 2^32)/100, set dividend = target*h2 mod 2^32 and set divisor = 10000.
REQ-018 For inverse BMR, SHALL compute signed 34-bit N = target - (625*height/100) + 5*age - C, where C = +5 if male and -161 if female; divisions truncate.
REQ-019 If N < 0, SHALL set err=1, result=0 and go to DONE; otherwise it SHALL set dividend = N[31:0] and divisor = 10.
REQ-020 DIV SHALL run an unsigned restoring divider, 1 quotient bit per cycle, for exactly 32 cycles, then load result=quotient, err=0 and go to DONE.
REQ-021 Latency SHALL be 33 edges from accept to out_valid for a legal op and 1 edge for an error.
REQ-022 In DONE, out_valid=1; result and err SHALL be held stable until out_valid && out_ready.
REQ-023 On out_valid && out_ready, SHALL go to IDLE; out_valid=0 and in_ready=1 from the next cycle.
REQ-024 SHALL keep only one request in flight; a new request is never accepted in the same cycle as a result handoff.
REQ-025 out_ready SHALL be ignored outside DONE.

Reset
REQ-026 rst=1 SHALL, at the next edge and from any state (including mid-DIV), force IDLE, out_valid=0, result=0, err=0 and clear the divider count.
REQ-027 rst SHALL dominate in_valid; no request is accepted on a reset edge and an interrupted operation produces no output.

Verification
REQ-028 Inverse BMI: height=175, target=2287, is_inv_bmi=1 -> 33 edges later out_valid=1, result=69, err=0.
REQ-029 Inverse BMR male: height=175, target=1700, funct7={1,30}, is_inv_bmr=1 -> result=75, err=0.
REQ-030 Inverse BMR female: same request with funct7={0,30} -> result=91; then target=500, funct7={1,0} -> out_valid 1 edge after accept, err=1, result=0.
REQ-031 Illegal opcode: both select bits high, then both low -> each gives err=1, result=0 one edge after accept.
REQ-032 Backpressure: hold out_ready=0 for 10 cycles in DONE -> result stable, in_ready=0; new in_valid requests are not accepted until the handoff.
REQ-033 Reset mid-op: assert rst at DIV cycle 15 -> next cycle IDLE, out_valid=0, in_ready=1; a following legal request gives the correct result.

Source files
------------

// File: rtl/calc_inverse_unit.sv
// Inverse BMI / BMR unit: target weight from a BMI or BMR request, using a
// 32-cycle restoring divider with a valid/ready handshake on both sides.
//
// state | meaning
// IDLE  | ready for a request
// PREP  | build dividend/divisor, or flag an illegal op / negative intermediate
// DIV   | one quotient bit per cycle, 32 cycles
// DONE  | result valid, held until out_ready
module calc_inverse_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        is_inv_bmi,
  input  logic        is_inv_bmr,
  input  logic [31:0] height,
  input  logic [31:0] target,
  input  logic [6:0]  funct7,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, PREP, DIV, DONE} state_t;

  state_t      state, state_nxt;
  logic        cap_bmi, cap_bmr, cap_male;
  logic [5:0]  cap_age;
  logic [31:0] cap_height, cap_target;
  logic [32:0] rem_q;
  logic [31:0] quo_q, dvs_q;
  logic [4:0]  cnt_q;
  logic [31:0] result_q;
  logic        err_q;

  // Inverse BMI operands (all products wrap at 32 bits)
  logic [31:0] h_sq, h2, bmi_dividend;
  assign h_sq         = cap_height * cap_height;
  assign h2           = h_sq / 32'd100;
  assign bmi_dividend = cap_target * h2;

  // Inverse BMR: N is evaluated wide and judged by its 34-bit sign
  logic [41:0] h625, h625_div;
  logic [43:0] n_wide;
  logic        n_neg, legal;
  assign h625     = {10'b0, cap_height} * 42'd625;
  assign h625_div = h625 / 42'd100;
  assign n_wide   = {12'b0, cap_target} + ({38'b0, cap_age} * 44'd5)
                  + (cap_male ? -44'd5 : 44'd161) - {2'b0, h625_div};
  assign n_neg    = n_wide[33];
  assign legal    = cap_bmi ^ cap_bmr;

  logic [32:0] rem_sh;
  logic        ge;
  logic [31:0] quo_nxt;
  assign rem_sh  = {rem_q[31:0], quo_q[31]};
  assign ge      = rem_sh >= {1'b0, dvs_q};
  assign quo_nxt = {quo_q[30:0], ge};

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = PREP;
      end
      PREP: begin
        if (!legal || (cap_bmr && n_neg)) state_nxt = DONE;
        else                              state_nxt = DIV;
      end
      DIV: begin
        if (cnt_q == 5'd31) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cap_bmi    <= 1'b0;
      cap_bmr    <= 1'b0;
      cap_male   <= 1'b0;
      cap_age    <= '0;
      cap_height <= '0;
      cap_target <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            cap_bmi    <= is_inv_bmi;
            cap_bmr    <= is_inv_bmr;
            cap_male   <= funct7[6];
            cap_age    <= funct7[5:0];
            cap_height <= height;
            cap_target <= target;
          end
        end
        PREP: begin
          cnt_q <= '0;
          rem_q <= '0;
          if (!legal || (cap_bmr && n_neg)) begin
            err_q    <= 1'b1;
            result_q <= '0;
          end else if (cap_bmi) begin
            quo_q <= bmi_dividend;
            dvs_q <= 32'd10000;
          end else begin
            quo_q <= n_wide[31:0];
            dvs_q <= 32'd10;
          end
        end
        DIV: begin
          rem_q <= ge ? (rem_sh - {1'b0, dvs_q}) : rem_sh;
          quo_q <= quo_nxt;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            result_q <= quo_nxt;
            err_q    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign result = result_q;
  assign err    = err_q;

endmodule
